// File: rtl/gate_chk_pkg.sv
// gate_chk_pkg: gate codes, checker state encoding and the reference gate function
package gate_chk_pkg;
  localparam int GATE_NAND = 0;
  localparam int GATE_AND  = 1;
  localparam int GATE_NOR  = 2;
  localparam int GATE_OR   = 3;
  localparam int GATE_XOR  = 4;
  localparam int GATE_XNOR = 5;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic logic gate_eval(input int code, input logic [3:0] vec, input int n);
    logic a, o, x;
    a = 1'b1;
    o = 1'b0;
    x = 1'b0;
    for (int i = 0; i < 4; i++)
      if (i < n) begin
        a &= vec[i];
        o |= vec[i];
        x ^= vec[i];
      end
    return code == GATE_NAND ? ~a : code == GATE_AND ? a : code == GATE_NOR ? ~o :
           code == GATE_OR ? o : code == GATE_XOR ? x : ~x;
  endfunction
endpackage

// File: rtl/gate_response_checker_if.sv
// gate_response_checker_if: sample handshake (in_valid/in_vec/in_q from source, in_ready back from checker)
interface gate_response_checker_if #(parameter int N_IN = 3);
  logic            in_valid;
  logic [N_IN-1:0] in_vec;
  logic            in_q;
  logic            in_ready;
  modport master (output in_valid, in_vec, in_q, input in_ready);
  modport slave (input in_valid, in_vec, in_q, output in_ready);
endinterface

// File: rtl/gate_ref_model.sv
// gate_ref_model: combinational reference gate; vec in, expected output exp
module gate_ref_model import gate_chk_pkg::*; #(
  parameter int N_IN = 3,
  parameter int GATE = GATE_NAND
) (
  input  logic [N_IN-1:0] vec,
  output logic            exp
);
  assign exp = gate_eval(GATE, 4'(vec), N_IN);
endmodule

// File: rtl/gate_response_checker.sv
// gate_response_checker: checks gate samples (clk, rst, start, handshake s) -> busy/done/pass/timeout, err_count, cov_map, first_err_*
module gate_response_checker import gate_chk_pkg::*; #(
  parameter int N_IN    = 3,
  parameter int GATE    = GATE_NAND,
  parameter int ERR_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  gate_response_checker_if.slave s,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   timeout,
  output logic [ERR_W-1:0]       err_count,
  output logic [(1<<N_IN)-1:0]   cov_map,
  output logic                   first_err_valid,
  output logic [N_IN-1:0]        first_err_vec
);
  localparam int NV = 1 << N_IN;
  localparam int IW = $clog2(TIMEOUT + 1);
  state_t state;
  logic [IW-1:0] idle;
  logic exp, acc, mism;
  logic [NV-1:0] cov_next;
  logic [ERR_W-1:0] err_next;
  gate_ref_model #(.N_IN(N_IN), .GATE(GATE)) u_ref (.vec(s.in_vec), .exp(exp));
  assign s.in_ready = state == RUN;
  assign busy = state == RUN;
  assign done = state == DONE;
  assign acc = s.in_valid & s.in_ready;
  assign mism = s.in_q != exp;
  assign cov_next = cov_map | (NV'(1) << s.in_vec);
  assign err_next = mism && !(&err_count) ? err_count + 1'b1 : err_count;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      idle <= '0;
      pass <= 1'b0;
      timeout <= 1'b0;
      err_count <= '0;
      cov_map <= '0;
      first_err_valid <= 1'b0;
      first_err_vec <= '0;
    end else if (start) begin
      state <= RUN;
      idle <= '0;
      pass <= 1'b0;
      timeout <= 1'b0;
      err_count <= '0;
      cov_map <= '0;
      first_err_valid <= 1'b0;
      first_err_vec <= '0;
    end else if (state == RUN) begin
      if (acc) begin
        idle <= '0;
        cov_map <= cov_next;
        err_count <= err_next;
        if (mism && !first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_vec <= s.in_vec;
        end
        if (&cov_next) begin
          state <= DONE;
          pass <= err_next == '0;
        end
      end else if (idle == IW'(TIMEOUT - 1)) begin
        state <= DONE;
        timeout <= 1'b1;
      end else
        idle <= idle + 1'b1;
    end
endmodule

// File: tb/tb_gate_response_checker.sv
// tb_gate_response_checker: directed scoreboard bench for a 3-input NAND checker (ERR_W 8 and 2)
module tb_gate_response_checker;
  localparam int TO = 16;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  always #5 clk = ~clk;
  gate_response_checker_if #(.N_IN(3)) ifc ();
  gate_response_checker_if #(.N_IN(3)) ifc2 ();
  assign ifc2.in_valid = ifc.in_valid;
  assign ifc2.in_vec = ifc.in_vec;
  assign ifc2.in_q = ifc.in_q;
  logic busy, done, pass, tmo, fev;
  logic [7:0] err, cov;
  logic [2:0] fvec;
  logic busy2, done2, pass2, tmo2, fev2;
  logic [1:0] err2;
  logic [7:0] cov2;
  logic [2:0] fvec2;
  gate_response_checker #(.N_IN(3), .GATE(0), .ERR_W(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .s(ifc.slave), .busy(busy), .done(done), .pass(pass),
    .timeout(tmo), .err_count(err), .cov_map(cov), .first_err_valid(fev), .first_err_vec(fvec));
  gate_response_checker #(.N_IN(3), .GATE(0), .ERR_W(2), .TIMEOUT(TO)) dut_s (
    .clk(clk), .rst(rst), .start(start), .s(ifc2.slave), .busy(busy2), .done(done2), .pass(pass2),
    .timeout(tmo2), .err_count(err2), .cov_map(cov2), .first_err_valid(fev2), .first_err_vec(fvec2));
  typedef struct {
    logic rdy, bsy, dn, ps, to, fev;
    logic [7:0] err, cov;
    logic [1:0] err2;
    logic [2:0] fvec;
  } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  int m_st, m_idle;
  logic [7:0] m_err, m_cov;
  logic [1:0] m_err2;
  logic m_fev, m_pass, m_to;
  logic [2:0] m_fvec;
  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
    end
  endtask
  task automatic model_clear();
    m_idle = 0; m_err = '0; m_err2 = '0; m_cov = '0;
    m_fev = 1'b0; m_fvec = '0; m_pass = 1'b0; m_to = 1'b0;
  endtask
  task automatic push();
    exp_t e;
    e.rdy = m_st == 1; e.bsy = m_st == 1; e.dn = m_st == 2; e.ps = m_pass; e.to = m_to;
    e.fev = m_fev; e.err = m_err; e.cov = m_cov; e.err2 = m_err2; e.fvec = m_fvec;
    sb.push_back(e);
  endtask
  task automatic compare();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    chk("in_ready", ifc.in_ready, e.rdy);
    chk("busy", busy, e.bsy);
    chk("done", done, e.dn);
    chk("pass", pass, e.ps);
    chk("timeout", tmo, e.to);
    chk("err_count", err, e.err);
    chk("cov_map", cov, e.cov);
    chk("first_err_valid", fev, e.fev);
    if (e.fev) chk("first_err_vec", fvec, e.fvec);
    chk("err_count_sat", err2, e.err2);
  endtask
  task automatic step(input logic st, input logic v, input logic [2:0] vec, input logic q);
    start = st; ifc.in_valid = v; ifc.in_vec = vec; ifc.in_q = q;
    if (st) begin
      model_clear();
      m_st = 1;
    end else if (m_st == 1) begin
      if (v) begin
        m_idle = 0;
        m_cov[vec] = 1'b1;
        if (q !== (~&vec)) begin
          if (m_err != 8'hFF) m_err++;
          if (m_err2 != 2'd3) m_err2++;
          if (!m_fev) begin m_fev = 1'b1; m_fvec = vec; end
        end
        if (m_cov == 8'hFF) begin m_st = 2; m_pass = m_err == 0; end
      end else if (m_idle == TO - 1) begin
        m_st = 2; m_to = 1'b1;
      end else m_idle++;
    end
    push();
    @(posedge clk);
    #1;
    compare();
    start = 1'b0; ifc.in_valid = 1'b0;
  endtask
  task automatic sweep(input logic [7:0] qs);
    for (int v = 0; v < 8; v++) step(0, 1, 3'(v), qs[v]);
  endtask
  initial begin
    ifc.in_valid = 1'b0; ifc.in_vec = '0; ifc.in_q = 1'b0;
    m_st = 0; model_clear();
    @(posedge clk); #1;
    push(); compare();
    rst = 1'b0;
    step(0, 1, 3'd0, 1'b0);
    step(0, 1, 3'd5, 1'b1);
    step(1, 0, 3'd0, 1'b0);
    sweep(8'h7F);
    chk("full_sweep_pass", pass, 1);
    chk("full_sweep_cov", cov, 8'hFF);
    for (int i = 0; i < 3; i++) step(0, 1, 3'd1, 1'b0);
    step(1, 1, 3'd0, 1'b0);
    sweep(8'hFB);
    chk("two_err_count", err, 2);
    chk("two_err_vec", fvec, 3'b010);
    step(1, 0, 3'd0, 1'b0);
    for (int v = 0; v < 7; v++) step(0, 1, 3'(v), 1'b1);
    for (int i = 0; i < TO + 2; i++) step(0, 0, 3'd7, 1'b0);
    chk("timeout_flag", tmo, 1);
    chk("timeout_cov", cov, 8'h7F);
    step(1, 0, 3'd0, 1'b0);
    step(0, 1, 3'd5, 1'b1);
    step(0, 1, 3'd0, 1'b1);
    step(0, 1, 3'd5, 1'b1);
    for (int v = 1; v < 5; v++) step(0, 1, 3'(v), 1'b1);
    step(0, 1, 3'd5, 1'b1);
    step(0, 1, 3'd6, 1'b1);
    step(0, 0, 3'd6, 1'b1);
    step(0, 1, 3'd7, 1'b0);
    chk("dup_pass", pass, 1);
    step(1, 0, 3'd0, 1'b0);
    for (int i = 0; i < 5; i++) step(0, 1, 3'd7, 1'b1);
    chk("sat_wide", err, 5);
    chk("sat_narrow", err2, 3);
    step(1, 1, 3'd7, 1'b1);
    for (int v = 0; v < 4; v++) step(0, 1, 3'(v), v == 2 ? 1'b0 : 1'b1);
    rst = 1'b1;
    #1;
    m_st = 0; model_clear();
    push(); compare();
    @(posedge clk); #1;
    rst = 1'b0;
    step(0, 1, 3'd3, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gate_response_checker.md
# gate_response_checker

Sequential response checker for the basic-gate library: the consuming end of the stimulus/monitor flow used for the combinational gates. It accepts (input vector, gate output) samples over a valid/ready handshake and compares each output against a built-in reference function. It tracks which of the 2^N_IN input combinations have been exercised and reports completion, pass/fail, error count and the first failing vector. It sits beside a gate under test in self-checking benches and on-chip gate self-test.

## Interface
- N_IN, 3, number of gate inputs (1..4)
- GATE, 0, reference function: 0 NAND, 1 AND, 2 NOR, 3 OR, 4 XOR, 5 XNOR
- ERR_W, 8, width of error counter
- TIMEOUT, 64, max idle cycles in RUN before abort (≥1)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin/restart a check run (single-cycle pulse)
- in_valid  in  1  sample present
- in_vec  in  N_IN  gate input vector (bit N_IN-1 = first operand, e.g. a)
- in_q  in  1  gate output observed for in_vec
- in_ready  out  1  checker accepts samples
- busy  out  1  run in progress
- done  out  1  run finished (held)
- pass  out  1  valid when done: full coverage and zero errors
- timeout  out  1  valid when done: run ended by idle timeout
- err_count  out  ERR_W  mismatches this run, saturating
- cov_map  out  2^N_IN  bit i set once vector i accepted
- first_err_valid  out  1  at least one mismatch recorded
- first_err_vec  out  N_IN  in_vec of first mismatch

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE; all outputs 0.
- IDLE: in_ready=0. start → RUN.
- RUN: in_ready=1, busy=1. Accept = in_valid & in_ready. On accept: exp = GATE(in_vec); set cov_map[in_vec]; if in_q≠exp, err_count += 1 (saturate at 2^ERR_W-1); if first_err_valid=0, capture in_vec, set first_err_valid.
- Repeated vectors: checked and counted; coverage unchanged.
- RUN → DONE on the edge accepting the last uncovered vector (cov_map becomes all-ones), or when the idle counter reaches TIMEOUT (timeout=1).
- Idle counter: cycles in RUN without an accept; cleared on accept and on entering RUN.
- DONE: in_ready=0, busy=0, done=1, pass = (err_count==0) & ~timeout. Results held until next start.
- start in RUN or DONE: restart; state RUN, clears cov_map, err_count, first_err_*, timeout, done, pass, idle counter. A sample presented in the start cycle is not accepted (in_ready is 0 in IDLE/DONE; in RUN the restart has priority and the sample is dropped).
- in_valid while in_ready=0: ignored; no stall required of source.
- Reset mid-run: immediate return to IDLE, all results cleared.

## Timing
- All state and outputs registered; in_ready, busy, done are decoded from state only.
- Accept at edge k → err_count, cov_map, first_err_* updated after edge k (1-cycle latency).
- Completing accept at edge k → done=1, pass valid after edge k; in_ready=0 from the same point.
- Timeout: entering RUN at edge s with no accepts → done=1, timeout=1 after edge s+TIMEOUT.
- Minimum run for N_IN=3: 8 consecutive accepts → done after the 8th accept edge.

## Structure
- Package gate_chk_pkg: GATE code constants, state encoding (IDLE/RUN/DONE), function gate_eval(code, vec) returning expected output.
- Sub-module gate_ref_model (combinational, GATE and N_IN parameters): in_vec → exp. Checker FSM, counters and coverage live in gate_response_checker.

## Test plan
- GATE=NAND, N_IN=3: start, then 8 samples 000..111 with correct q (1,1,1,1,1,1,1,0) back-to-back → done one cycle after the last accept, pass=1, err_count=0, cov_map=8'hFF.
- Same, with q=1 for vector 111 and q=0 for 010 → err_count=2, first_err_vec=3'b010, pass=0.
- Only vectors 000..110 sent, then in_valid low → done after TIMEOUT idle cycles, timeout=1, pass=0, cov_map=8'h7F.
- Duplicate vector 101 sent 3 times among a full sweep → coverage completes at last new vector, err_count unaffected by correct duplicates; ERR_W=2 with 5 mismatches → err_count saturates at 3.
- Assert rst after 4 accepts → all outputs 0, state IDLE; start pulse in DONE with in_valid=1 → results cleared, that sample not counted, in_ready=1 next cycle.
